rob_retire_source: RTL and testbench
====================================

Name: rob_retire_source

Overview:
- Reorder buffer that supplies the retire stage.
- Allocates entries in program order at dispatch and records completion results from the complete stage.
- Presents the oldest entry to retire as a CO_RE_PACKET, plus its head index.
- Advances the head when retire asserts move_head. It is the producer end of the retire interface.

Parameters:
DEPTH, `ROB_SZ, number of entries; power of two, at least 4
IDX_W, $clog2(DEPTH), entry index width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-low: state is cleared on a rising clock edge when reset==0
dispatch_valid  in  1  allocate one entry this cycle
dispatch_dest_reg_idx  in  5  architectural destination register
dispatch_NPC  in  XLEN  next PC of the dispatched instruction
dispatch_ready  out  1  entry is free (count<DEPTH)
dispatch_rob_index  out  IDX_W  index the next allocation will receive (tail)
complete_valid  in  1  completion write this cycle
complete_rob_index  in  IDX_W  entry being completed
complete_result  in  XLEN  result value
complete_take_branch  in  1  resolved branch taken
complete_halt  in  1  halt instruction
complete_illegal  in  1  illegal instruction
squash  in  1  flush all entries
co_package  out  $bits(CO_RE_PACKET)  head entry to retire
rob_head  out  IDX_W  head pointer
move_head  in  1  retire consumed the head entry
count  out  IDX_W+1  occupied entries

Behaviour:
- Reset (reset==0 at posedge):
  - head=0, tail=0, count=0.
  - All entry valid and done bits are 0.
  - Outputs: co_package all-zero with valid=0, rob_head=0, dispatch_ready=1, dispatch_rob_index=0.
- Reset wins over every other input, including mid-sequence dispatch, complete and squash.
- Entry state: valid, done, dest_reg_idx, NPC, result, take_branch, halt, illegal.
- Dispatch (dispatch_valid && dispatch_ready):
  - Entry[tail] gets valid=1, done=0 and the dispatch fields.
  - tail increments mod DEPTH.
  - dispatch_valid while not ready is ignored, with no state change.
- dispatch_ready depends only on registered count. When the buffer is full, a same-cycle pop does not enable dispatch.
- Complete (complete_valid):
  - If entry[complete_rob_index].valid, set done=1 and store result, take_branch, halt and illegal.
  - Completion to an invalid entry is ignored.
  - Completion to an already-done entry overwrites its fields.
- Head presentation (from registered state only):
  - co_package.valid = entry[head].valid && entry[head].done.
  - rob_index=head; the remaining fields come from entry[head].
  - When not valid, all data fields are driven 0.
- Retire (move_head && co_package.valid):
  - Clear entry[head].valid and done.
  - head increments mod DEPTH.
  - move_head while co_package.valid==0 is ignored.
- count next value = count + dispatch_fire - retire_fire. Simultaneous dispatch and retire leaves count unchanged.
- Same-cycle completion and dispatch to one index cannot occur, because the complete stage never targets the tail. No arbitration is needed.
- Completion of the head entry is visible on co_package the following cycle (1-cycle latency).
- After retiring an entry with halt=1, no further entries are presented until reset. co_package.valid is held at 0.
- squash (when reset==1):
  - Clear all valid and done bits; head=tail=0, count=0.
  - squash has priority over same-cycle dispatch, complete and move_head.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0. Full is count==DEPTH; empty is count==0.

Optional Feature:
- ROB_BYPASS_EN defined:
  - When complete_valid targets head while entry[head] is valid and not done, co_package is formed combinationally from the complete_* inputs that cycle (0-cycle latency).
  - move_head may retire it in the same cycle. The entry is then cleared and is not written as done.
- ROB_BYPASS_EN undefined:
  - Head completion becomes visible one cycle later, as described under Behaviour.

Test Plan:
- Basic flow:
  - Stimulus: after reset, dispatch dest=2, NPC=1 (index 0); next cycle complete index 0, result=1; move_head=1 while valid.
  - Required: co_package {valid=1, result=1, NPC=1, dest_reg_idx=2, rob_index=0}; then rob_head=1, count=0.
- In-order retire:
  - Stimulus: dispatch 3 entries; complete index 2 then index 1.
  - Required: co_package.valid stays 0 until index 0 completes; then retire order is 0, 1, 2.
- Full and wrap:
  - Stimulus: DEPTH=8, dispatch 8 entries.
  - Required: dispatch_ready=0 and count=8.
  - Stimulus: dispatch while also retiring head.
  - Required: the dispatch is rejected that cycle.
  - Stimulus: a later dispatch.
  - Required: it is accepted with dispatch_rob_index=0 after the wrap.
- Ignored inputs:
  - Stimulus: move_head=1 with the head not done.
  - Required: head unchanged.
  - Stimulus: complete to an invalid index 5.
  - Required: no entry changes.
- Squash and reset:
  - Stimulus: 4 entries pending; squash together with dispatch_valid.
  - Required: count=0, head=tail=0, co_package.valid=0.
  - Stimulus: reset=0 mid-stream.
  - Required: the same cleared state.
- Halt and bypass:
  - Stimulus: retire a halt entry.
  - Required: later completed entries are never presented.
  - Stimulus (ROB_BYPASS_EN defined): complete the head with result=7.
  - Required: co_package.valid=1 and result=7 in the same cycle.

Source files
------------

// File: rtl/rob_retire_source.sv
// rob_retire_source: reorder buffer that allocates at dispatch, records completions and
// presents the oldest completed entry to retire. Optional define ROB_BYPASS_EN forwards a head completion in the same cycle.
`ifndef ROB_SZ
`define ROB_SZ 8
`endif

package rob_retire_pkg;
   localparam int ROB_DEPTH = `ROB_SZ;
   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
   localparam int XLEN      = 32;

   typedef struct packed {
      logic                 valid;
      logic [ROB_IDX_W-1:0] rob_index;
      logic [4:0]           dest_reg_idx;
      logic [XLEN-1:0]      NPC;
      logic [XLEN-1:0]      result;
      logic                 take_branch;
      logic                 halt;
      logic                 illegal;
   } CO_RE_PACKET;
endpackage

module rob_retire_source
   import rob_retire_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dispatch_valid,
   input  logic [4:0]        dispatch_dest_reg_idx,
   input  logic [XLEN-1:0]   dispatch_NPC,
   output logic              dispatch_ready,
   output logic [IDX_W-1:0]  dispatch_rob_index,
   input  logic              complete_valid,
   input  logic [IDX_W-1:0]  complete_rob_index,
   input  logic [XLEN-1:0]   complete_result,
   input  logic              complete_take_branch,
   input  logic              complete_halt,
   input  logic              complete_illegal,
   input  logic              squash,
   output CO_RE_PACKET       co_package,
   output logic [IDX_W-1:0]  rob_head,
   input  logic              move_head,
   output logic [IDX_W:0]    count
);

   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             halted_q, halted_d;

   logic [DEPTH-1:0] valid_vec, done_vec, br_vec, halt_vec, ill_vec;
   logic [4:0]       dest_arr   [DEPTH];
   logic [XLEN-1:0]  npc_arr    [DEPTH];
   logic [XLEN-1:0]  result_arr [DEPTH];

   logic        dispatch_fire;
   logic        retire_fire;
   logic        head_valid;
   logic        head_done;
   CO_RE_PACKET co_d;

   assign dispatch_ready     = (count_q < FULL_CNT);
   assign dispatch_fire      = dispatch_valid && dispatch_ready;
   assign dispatch_rob_index = tail_q;
   assign rob_head           = head_q;
   assign count              = count_q;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic            valid_q, done_q;
      logic [4:0]      dest_q;
      logic [XLEN-1:0] npc_q, result_q;
      logic            br_q, halt_q, ill_q;
      logic            alloc, cmp, ret;

      assign alloc = dispatch_fire && (tail_q == IDX_W'(gi));
      assign cmp   = complete_valid && valid_q && (complete_rob_index == IDX_W'(gi));
      assign ret   = retire_fire && (head_q == IDX_W'(gi));

      // Retire is applied last so a same-cycle (bypassed) completion never leaves the entry done.
      always_ff @(posedge clock) begin
         if (!reset) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
         end else if (squash) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            if (alloc) begin
               valid_q <= 1'b1;
               done_q  <= 1'b0;
            end
            if (cmp) begin
               done_q <= 1'b1;
            end
            if (ret) begin
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
         end
      end

      always_ff @(posedge clock) begin
         if (alloc) begin
            dest_q <= dispatch_dest_reg_idx;
            npc_q  <= dispatch_NPC;
         end
         if (cmp) begin
            result_q <= complete_result;
            br_q     <= complete_take_branch;
            halt_q   <= complete_halt;
            ill_q    <= complete_illegal;
         end
      end

      assign valid_vec[gi]  = valid_q;
      assign done_vec[gi]   = done_q;
      assign br_vec[gi]     = br_q;
      assign halt_vec[gi]   = halt_q;
      assign ill_vec[gi]    = ill_q;
      assign dest_arr[gi]   = dest_q;
      assign npc_arr[gi]    = npc_q;
      assign result_arr[gi] = result_q;
   end

   always_comb begin
      co_d       = '0;
      head_valid = valid_vec[head_q];
      head_done  = done_vec[head_q];
      if (!halted_q && head_valid && head_done) begin
         co_d.valid        = 1'b1;
         co_d.rob_index    = head_q;
         co_d.dest_reg_idx = dest_arr[head_q];
         co_d.NPC          = npc_arr[head_q];
         co_d.result       = result_arr[head_q];
         co_d.take_branch  = br_vec[head_q];
         co_d.halt         = halt_vec[head_q];
         co_d.illegal      = ill_vec[head_q];
      end
`ifdef ROB_BYPASS_EN
      if (!halted_q && head_valid && !head_done && complete_valid &&
          (complete_rob_index == head_q)) begin
         co_d.valid        = 1'b1;
         co_d.rob_index    = head_q;
         co_d.dest_reg_idx = dest_arr[head_q];
         co_d.NPC          = npc_arr[head_q];
         co_d.result       = complete_result;
         co_d.take_branch  = complete_take_branch;
         co_d.halt         = complete_halt;
         co_d.illegal      = complete_illegal;
      end
`endif
   end

   assign co_package  = co_d;
   assign retire_fire = move_head && co_d.valid;

   // A retired halt freezes presentation; only reset releases it, squash does not.
   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      halted_d = halted_q;
      if (squash) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (dispatch_fire) begin
            tail_d = tail_q + 1'b1;
         end
         if (retire_fire) begin
            head_d = head_q + 1'b1;
            if (co_d.halt) begin
               halted_d = 1'b1;
            end
         end
         count_d = count_q + {{IDX_W{1'b0}}, dispatch_fire} - {{IDX_W{1'b0}}, retire_fire};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         halted_q <= halted_d;
      end
   end

endmodule

// File: tb/tb_rob_retire_source.sv
// Directed bench for rob_retire_source (default DEPTH=8); handles both ROB_BYPASS_EN builds.
module tb_rob_retire_source;
   import rob_retire_pkg::*;

   localparam int DEPTH = ROB_DEPTH;
   localparam int IDX_W = ROB_IDX_W;

   logic              clock;
   logic              reset;
   logic              dispatch_valid;
   logic [4:0]        dispatch_dest_reg_idx;
   logic [XLEN-1:0]   dispatch_NPC;
   logic              dispatch_ready;
   logic [IDX_W-1:0]  dispatch_rob_index;
   logic              complete_valid;
   logic [IDX_W-1:0]  complete_rob_index;
   logic [XLEN-1:0]   complete_result;
   logic              complete_take_branch;
   logic              complete_halt;
   logic              complete_illegal;
   logic              squash;
   CO_RE_PACKET       co_package;
   logic [IDX_W-1:0]  rob_head;
   logic              move_head;
   logic [IDX_W:0]    count;

   int n_cmp = 0;
   int n_err = 0;

   rob_retire_source #(.DEPTH(DEPTH)) dut (
      .clock                (clock),
      .reset                (reset),
      .dispatch_valid       (dispatch_valid),
      .dispatch_dest_reg_idx(dispatch_dest_reg_idx),
      .dispatch_NPC         (dispatch_NPC),
      .dispatch_ready       (dispatch_ready),
      .dispatch_rob_index   (dispatch_rob_index),
      .complete_valid       (complete_valid),
      .complete_rob_index   (complete_rob_index),
      .complete_result      (complete_result),
      .complete_take_branch (complete_take_branch),
      .complete_halt        (complete_halt),
      .complete_illegal     (complete_illegal),
      .squash               (squash),
      .co_package           (co_package),
      .rob_head             (rob_head),
      .move_head            (move_head),
      .count                (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp)
         $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
      else begin
         n_err++;
         $display("FAIL %-12s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   function automatic CO_RE_PACKET pkt(input logic [IDX_W-1:0] idx, input logic [4:0] dest,
                                       input logic [XLEN-1:0] npc, input logic [XLEN-1:0] res,
                                       input logic br, input logic h, input logic il);
      CO_RE_PACKET p;
      p.valid        = 1'b1;
      p.rob_index    = idx;
      p.dest_reg_idx = dest;
      p.NPC          = npc;
      p.result       = res;
      p.take_branch  = br;
      p.halt         = h;
      p.illegal      = il;
      return p;
   endfunction

   task automatic do_dispatch(input logic [4:0] dest, input logic [XLEN-1:0] npc);
      dispatch_valid        = 1'b1;
      dispatch_dest_reg_idx = dest;
      dispatch_NPC          = npc;
      tick();
      dispatch_valid = 1'b0;
   endtask

   task automatic do_complete(input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] res,
                              input logic br, input logic h, input logic il);
      complete_valid       = 1'b1;
      complete_rob_index   = idx;
      complete_result      = res;
      complete_take_branch = br;
      complete_halt        = h;
      complete_illegal     = il;
      tick();
      complete_valid       = 1'b0;
      complete_take_branch = 1'b0;
      complete_halt        = 1'b0;
      complete_illegal     = 1'b0;
   endtask

   task automatic do_retire();
      move_head = 1'b1;
      tick();
      move_head = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      dispatch_valid = 1'b0; dispatch_dest_reg_idx = '0; dispatch_NPC = '0;
      complete_valid = 1'b0; complete_rob_index = '0; complete_result = '0;
      complete_take_branch = 1'b0; complete_halt = 1'b0; complete_illegal = 1'b0;
      squash = 1'b0; move_head = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_count", 128'(count), 128'(0));
      chk("rst_head", 128'(rob_head), 128'(0));
      chk("rst_ready", 128'(dispatch_ready), 128'(1));
      chk("rst_tail", 128'(dispatch_rob_index), 128'(0));
      chk("rst_pkt", 128'(co_package), 128'(0));
      reset = 1'b1;

      // Basic flow
      do_dispatch(5'd2, 32'd1);
      chk("bf_count", 128'(count), 128'(1));
      chk("bf_tail", 128'(dispatch_rob_index), 128'(1));
      chk("bf_novalid", 128'(co_package.valid), 128'(0));
      do_complete(3'd0, 32'd1, 1'b0, 1'b0, 1'b0);
      chk("bf_pkt", 128'(co_package), 128'(pkt(3'd0, 5'd2, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0)));
      do_retire();
      chk("bf_head", 128'(rob_head), 128'(1));
      chk("bf_count0", 128'(count), 128'(0));

      // In-order retire: entries 1,2,3; complete 3 then 2 then 1
      do_dispatch(5'd3, 32'h10);
      do_dispatch(5'd4, 32'h14);
      do_dispatch(5'd5, 32'h18);
      chk("io_count", 128'(count), 128'(3));
      do_complete(3'd3, 32'hA3, 1'b1, 1'b0, 1'b0);
      chk("io_wait3", 128'(co_package.valid), 128'(0));
      do_complete(3'd2, 32'hA2, 1'b0, 1'b0, 1'b0);
      chk("io_wait2", 128'(co_package.valid), 128'(0));
      do_complete(3'd1, 32'hA1, 1'b0, 1'b0, 1'b0);
      chk("io_pkt1", 128'(co_package), 128'(pkt(3'd1, 5'd3, 32'h10, 32'hA1, 1'b0, 1'b0, 1'b0)));
      do_retire();
      chk("io_pkt2", 128'(co_package), 128'(pkt(3'd2, 5'd4, 32'h14, 32'hA2, 1'b0, 1'b0, 1'b0)));
      do_retire();
      chk("io_pkt3", 128'(co_package), 128'(pkt(3'd3, 5'd5, 32'h18, 32'hA3, 1'b1, 1'b0, 1'b0)));
      do_retire();
      chk("io_empty", 128'(co_package), 128'(0));
      chk("io_count0", 128'(count), 128'(0));
      chk("io_head", 128'(rob_head), 128'(4));

      // Ignored inputs
      do_dispatch(5'd6, 32'h20);
      do_retire();
      chk("ig_head", 128'(rob_head), 128'(4));
      chk("ig_count", 128'(count), 128'(1));
      do_complete(3'd5, 32'h55, 1'b0, 1'b0, 1'b0);
      chk("ig_pkt", 128'(co_package), 128'(0));
      chk("ig_count2", 128'(count), 128'(1));
      chk("ig_tail", 128'(dispatch_rob_index), 128'(5));

      // Squash with 4 pending, together with dispatch and complete
      do_dispatch(5'd7, 32'h24);
      do_dispatch(5'd8, 32'h28);
      do_dispatch(5'd9, 32'h2C);
      chk("sq_count4", 128'(count), 128'(4));
      squash = 1'b1; dispatch_valid = 1'b1; complete_valid = 1'b1; complete_rob_index = 3'd4;
      tick();
      squash = 1'b0; dispatch_valid = 1'b0; complete_valid = 1'b0;
      chk("sq_count", 128'(count), 128'(0));
      chk("sq_head", 128'(rob_head), 128'(0));
      chk("sq_tail", 128'(dispatch_rob_index), 128'(0));
      chk("sq_pkt", 128'(co_package), 128'(0));

      // Reset mid-stream
      do_dispatch(5'd1, 32'h30);
      do_dispatch(5'd2, 32'h34);
      do_complete(3'd0, 32'h11, 1'b0, 1'b0, 1'b0);
      chk("rm_pkt", 128'(co_package), 128'(pkt(3'd0, 5'd1, 32'h30, 32'h11, 1'b0, 1'b0, 1'b0)));
      reset = 1'b0; dispatch_valid = 1'b1; complete_valid = 1'b1; complete_rob_index = 3'd1;
      move_head = 1'b1;
      tick();
      reset = 1'b1; dispatch_valid = 1'b0; complete_valid = 1'b0; move_head = 1'b0;
      chk("rm_count", 128'(count), 128'(0));
      chk("rm_head", 128'(rob_head), 128'(0));
      chk("rm_tail", 128'(dispatch_rob_index), 128'(0));
      chk("rm_pkt0", 128'(co_package), 128'(0));
      chk("rm_ready", 128'(dispatch_ready), 128'(1));

      // Full and wrap
      for (int i = 0; i < 8; i++) do_dispatch(5'(i + 1), 32'(32'h100 + 4 * i));
      chk("fu_count", 128'(count), 128'(8));
      chk("fu_ready", 128'(dispatch_ready), 128'(0));
      chk("fu_tail", 128'(dispatch_rob_index), 128'(0));
      do_complete(3'd0, 32'h200, 1'b0, 1'b0, 1'b0);
      chk("fu_pkt", 128'(co_package), 128'(pkt(3'd0, 5'd1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0)));
      dispatch_valid = 1'b1; dispatch_dest_reg_idx = 5'd9; dispatch_NPC = 32'h300; move_head = 1'b1;
      tick();
      dispatch_valid = 1'b0; move_head = 1'b0;
      chk("fu_rej_cnt", 128'(count), 128'(7));
      chk("fu_rej_head", 128'(rob_head), 128'(1));
      chk("fu_rej_tail", 128'(dispatch_rob_index), 128'(0));
      chk("fu_ready1", 128'(dispatch_ready), 128'(1));
      do_dispatch(5'd9, 32'h300);
      chk("fu_acc_cnt", 128'(count), 128'(8));
      chk("fu_acc_tail", 128'(dispatch_rob_index), 128'(1));
      squash = 1'b1;
      tick();
      squash = 1'b0;
      chk("fu_sq_cnt", 128'(count), 128'(0));

      // Head completion latency (bypass build presents it in the same cycle)
      do_dispatch(5'd10, 32'h400);
      complete_valid = 1'b1; complete_rob_index = 3'd0; complete_result = 32'd7;
      #1;
`ifdef ROB_BYPASS_EN
      chk("bp_pkt", 128'(co_package), 128'(pkt(3'd0, 5'd10, 32'h400, 32'd7, 1'b0, 1'b0, 1'b0)));
      move_head = 1'b1;
      tick();
      move_head = 1'b0; complete_valid = 1'b0;
`else
      chk("bp_none", 128'(co_package.valid), 128'(0));
      tick();
      complete_valid = 1'b0;
      chk("bp_pkt", 128'(co_package), 128'(pkt(3'd0, 5'd10, 32'h400, 32'd7, 1'b0, 1'b0, 1'b0)));
      do_retire();
`endif
      chk("bp_count", 128'(count), 128'(0));
      chk("bp_head", 128'(rob_head), 128'(1));

      // Halt: nothing presented after a retired halt
      do_dispatch(5'd1, 32'h500);
      do_dispatch(5'd2, 32'h504);
      do_complete(3'd1, 32'd0, 1'b0, 1'b1, 1'b0);
      do_complete(3'd2, 32'h22, 1'b0, 1'b0, 1'b0);
      chk("ht_pkt", 128'(co_package), 128'(pkt(3'd1, 5'd1, 32'h500, 32'd0, 1'b0, 1'b1, 1'b0)));
      do_retire();
      chk("ht_pkt0", 128'(co_package), 128'(0));
      chk("ht_count", 128'(count), 128'(1));
      chk("ht_head", 128'(rob_head), 128'(2));
      tick(); tick(); tick();
      do_retire();
      chk("ht_hold", 128'(co_package.valid), 128'(0));
      chk("ht_count2", 128'(count), 128'(1));
      chk("ht_head2", 128'(rob_head), 128'(2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
